aes_inv_cipher: RTL and testbench

Iterative AES-128 decryption core, the inverse of the encryption datapath. It consumes the 160-byte round-key bus produced by wholekeyexpand plus the original cipher key. It applies the rounds in reverse order, one round per clock, and returns the 16-byte plaintext over a valid/ready handshake. Byte layout matches the encryption side: matrix element (row r, col c) lives at index 15-(4r+c), so index 15 is the top-left byte and FIPS byte 0.

---
 rtl/aes_inv_cipher.sv | 187 ++++++++++++++++++
 tb/tb_aes_inv_cipher.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher.sv
// aes_inv_cipher: iterative AES-128 decryption, one inverse round per clock, valid/ready on both sides.
// Optional AES_INV_KEYLATCH_EN: key and round keys are registered at accept so upstream may move on.
module aes_inv_cipher #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0][7:0]  cipher,
  input  logic [15:0][7:0]  key,
  input  logic [159:0][7:0] roundkeys,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0][7:0]  plain,
  output logic              busy
);

  if (NUM_ROUNDS != 10) begin : g_bad_rounds
    $error("aes_inv_cipher supports only NUM_ROUNDS = 10");
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sub_byte(input logic [7:0] x);
    logic [10:0] idx;
    idx = {x, 3'b000};
    return INV_SBOX[11'd2047 - idx -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Element (r,c) sits at byte 15-(4r+c); row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[8*(15-(4*r+c)) +: 8] = s[8*(15-(4*r+((c-r+4)%4))) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[8*i +: 8] = inv_sub_byte(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    logic [7:0]   m9 [4];
    logic [7:0]   mb [4];
    logic [7:0]   md [4];
    logic [7:0]   me [4];
    logic [7:0]   x2, x4, x8;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r]  = s[8*(15-(4*r+c)) +: 8];
        x2    = xt(a[r]);
        x4    = xt(x2);
        x8    = xt(x4);
        m9[r] = x8 ^ a[r];
        mb[r] = x8 ^ x2 ^ a[r];
        md[r] = x8 ^ x4 ^ a[r];
        me[r] = x8 ^ x4 ^ x2;
      end
      o[8*(15-c)  +: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      o[8*(11-c)  +: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      o[8*(7-c)   +: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      o[8*(3-c)   +: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    return o;
  endfunction

  state_e        st_q;
  logic [3:0]    rcnt_q;
  logic [127:0]  data_q, plain_q;
  logic          in_ready_q, out_valid_q, busy_q;
  logic          accept;
  logic [1279:0] rk_live, rk_use;
  logic [127:0]  key_use, rk10, rk_cur, sub_sr, round_d, final_d;
  logic [127:0]  rk_arr [16];

  assign accept  = in_valid && in_ready_q;
  assign rk_live = roundkeys;
  assign rk10    = rk_live[1279 -: 128];

`ifdef AES_INV_KEYLATCH_EN
  logic [127:0]  key_q;
  logic [1279:0] rk_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q <= '0;
      rk_q  <= '0;
    end else if (accept) begin
      key_q <= key;
      rk_q  <= rk_live;
    end
  end

  assign key_use = key_q;
  assign rk_use  = rk_q;
`else
  assign key_use = key;
  assign rk_use  = rk_live;
`endif

  // Round k key lives at bits [128k-1 -: 128]; unused slots read as zero.
  always_comb begin
    for (int k = 0; k < 16; k++) rk_arr[k] = '0;
    for (int k = 1; k <= 10; k++) rk_arr[k] = rk_use[128*(k-1) +: 128];
  end

  assign rk_cur  = rk_arr[rcnt_q];
  assign sub_sr  = inv_sub_bytes(inv_shift_rows(data_q));
  assign round_d = inv_mix_columns(sub_sr ^ rk_cur);
  assign final_d = sub_sr ^ key_use;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      rcnt_q      <= 4'd0;
      data_q      <= '0;
      plain_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (st_q)
        IDLE: begin
          if (accept) begin
            data_q     <= cipher ^ rk10;
            rcnt_q     <= 4'd9;
            st_q       <= ROUND;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ROUND: begin
          data_q <= round_d;
          rcnt_q <= rcnt_q - 4'd1;
          if (rcnt_q == 4'd1) st_q <= FINAL;
        end
        FINAL: begin
          data_q      <= final_d;
          plain_q     <= final_d;
          st_q        <= DONE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            st_q        <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign plain     = plain_q;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Bench for aes_inv_cipher: FIPS-197 reference model with S-box built from GF(2^8) math, directed vectors.
module tb_aes_inv_cipher;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [15:0][7:0]  cipher;
  logic [15:0][7:0]  key;
  logic [159:0][7:0] roundkeys;
  logic              out_valid;
  logic              out_ready;
  logic [15:0][7:0]  plain;
  logic              busy;

  aes_inv_cipher #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cipher(cipher), .key(key), .roundkeys(roundkeys),
    .out_valid(out_valid), .out_ready(out_ready), .plain(plain), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] exp_q [$];
  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  // ---------------- reference model (FIPS byte order) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sboxes();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_t[x]  = s;
      isbox_t[s] = 8'(x);
    end
  endtask

  // Round k key at [128k +: 128], FIPS byte order.
  function automatic logic [1407:0] expand_key(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    o = '0;
    for (int r = 0; r <= 10; r++) o[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return o;
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] c_in, input logic [1407:0] rk);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [7:0] a [4];
    logic [7:0] coef [4];
    logic [127:0] o;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = c_in[127-8*(4*c+r) -: 8] ^ rk[128*10 + 127-8*(4*c+r) -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][(c+r)%4] = s[r][c];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r][c] = isbox_t[t[r][c]] ^ rk[128*rnd + 127-8*(4*c+r) -: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) a[j] = s[j][c];
          for (int r = 0; r < 4; r++) begin
            s[r][c] = 8'h00;
            for (int j = 0; j < 4; j++) s[r][c] = s[r][c] ^ gmul(coef[(j-r+4)%4], a[j]);
          end
        end
      end
    end
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) o[127-8*(4*c+r) -: 8] = s[r][c];
    return o;
  endfunction

  // FIPS byte n is (row n%4, col n/4); the core keeps (r,c) at byte 15-(4r+c).
  function automatic logic [127:0] to_mat(input logic [127:0] f);
    logic [127:0] m;
    m = '0;
    for (int n = 0; n < 16; n++) m[8*(15-(4*(n%4)+n/4)) +: 8] = f[8*(15-n) +: 8];
    return m;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every cycle with out_valid, plain must equal the oldest expected block.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out: got %h want none", plain);
      end else begin
        if (plain !== exp_q[0]) begin
          n_err++;
          $display("FAIL plain: got %h want %h", plain, exp_q[0]);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic send_block(input logic [127:0] c_f, input logic [1407:0] rk_all,
                            input logic [127:0] exp, input bit corrupt);
    logic [1279:0] busv;
    int n;
    for (int k = 1; k <= 10; k++) busv[128*(k-1) +: 128] = to_mat(rk_all[128*k +: 128]);
    cipher    = to_mat(c_f);
    key       = to_mat(rk_all[127:0]);
    roundkeys = busv;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check_int("accept_wait", int'(in_ready), 1);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (corrupt) roundkeys = '1;
  endtask

  task automatic wait_out(input int lat0, output int lat, output int bcnt);
    lat  = lat0;
    bcnt = 0;
    while (!out_valid && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) check_int("out_timeout", 0, 1);
  endtask

  logic [1407:0] rkb, rkc, rk_bad;
  logic [127:0]  exp6, held;
  int lat, bcnt;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cipher = '0; key = '0; roundkeys = '0;
    build_sboxes();
    rkb = expand_key(KB);
    rkc = expand_key(KC);

    check("pin_rk10_b", rkb[128*10 +: 128], RK10_B);
    check("pin_model_b", model_dec(CB, rkb), PB);
    check("pin_model_c1", model_dec(CC, rkc), PC);

    repeat (3) @(posedge clk);
    #1;
    check_int("rst_in_ready", int'(in_ready), 1);
    check_int("rst_out_valid", int'(out_valid), 0);
    check_int("rst_busy", int'(busy), 0);
    check("rst_plain", plain, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // App. B with latency and busy window
    send_block(CB, rkb, to_mat(PB), 1'b0);
    wait_out(0, lat, bcnt);
    check_int("lat_b", lat, 10);
    check_int("busy_cycles_b", bcnt, 10);
    check_int("busy_done_b", int'(busy), 0);
    check_int("in_ready_done_b", int'(in_ready), 0);

    // App. C.1
    send_block(CC, rkc, to_mat(PC), 1'b0);
    wait_out(0, lat, bcnt);
    check_int("lat_c1", lat, 10);

    // Backpressure
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_block(CB, rkb, to_mat(PB), 1'b0);
    wait_out(0, lat, bcnt);
    check_int("lat_bp", lat, 10);
    held = plain;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_plain_held", plain, held);
      check_int("bp_out_valid", int'(out_valid), 1);
      check_int("bp_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_int("bp_release_in_ready", int'(in_ready), 1);
    check_int("bp_release_out_valid", int'(out_valid), 0);

    // Reset mid-operation
    send_block(CC, rkc, to_mat(PC), 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    check_int("midrst_in_ready", int'(in_ready), 1);
    check_int("midrst_out_valid", int'(out_valid), 0);
    check_int("midrst_busy", int'(busy), 0);
    check("midrst_plain", plain, '0);
    rst_n = 1'b1;
    send_block(CB, rkb, to_mat(PB), 1'b0);
    wait_out(0, lat, bcnt);
    check_int("lat_after_rst", lat, 10);

    // in_valid with a different block during ROUND is ignored
    send_block(CC, rkc, to_mat(PC), 1'b0);
    in_valid = 1'b1;
    cipher   = to_mat(CB);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_int("round_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    wait_out(4, lat, bcnt);
    check_int("lat_ignore", lat, 10);

    // Round keys corrupted right after accept
`ifdef AES_INV_KEYLATCH_EN
    rk_bad = rkb;
    exp6   = to_mat(PB);
`else
    rk_bad = rkb;
    for (int k = 1; k <= 9; k++) rk_bad[128*k +: 128] = '1;
    exp6   = to_mat(model_dec(CB, rk_bad));
`endif
    send_block(CB, rkb, exp6, 1'b1);
    wait_out(0, lat, bcnt);
    check_int("lat_corrupt", lat, 10);

    repeat (4) begin @(posedge clk); #1; end
    check_int("drain", exp_q.size(), 0);
    check_int("idle_end", int'(in_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
